mem_bus_arb: RTL

Two-port memory bus arbiter that shares the single external memory bus between the instruction-fetch port and the MEM-stage data port. It sits between the IF-stage fetch interface, the MEM-stage `mem_top` bus interface and the downstream bus bridge. It grants one transaction at a time using round-robin on ties and latches the granted request's payload. It also runs a response watchdog, so a hung downstream returns an error instead of stalling the pipeline.

---
 rtl/mem_bus_arb_pkg.sv | 37 +++
 rtl/mem_bus_arb_wdt.sv | 37 +++
 rtl/mem_bus_arb.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arb_pkg.sv
// mem_bus_arb_pkg: shared types and constants for the two-port memory bus
// arbiter. It holds the bus widths, the FSM state encoding, the grant
// encoding, the response codes and the round-robin pick helper.
package mem_bus_arb_pkg;

   localparam int INST_ADDR_BUS = 64;
   localparam int DATA_ADDR_BUS = 64;
   localparam int DATA_BUS      = 64;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_BUSY  = 2'd1,
      ARB_DRAIN = 2'd2
   } arb_state_e;

   typedef enum logic {
      ARB_GRANT_IF  = 1'b0,
      ARB_GRANT_MEM = 1'b1
   } arb_grant_e;

   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [1:0] RESP_ERR  = 2'b10;

   // A single requester always wins. On a tie, the port that did not
   // complete last wins.
   function automatic arb_grant_e pick_grant(input logic if_v,
                                             input logic mem_v,
                                             input arb_grant_e last);
      if (if_v && mem_v)
         return (last == ARB_GRANT_IF) ? ARB_GRANT_MEM : ARB_GRANT_IF;
      else if (mem_v)
         return ARB_GRANT_MEM;
      else
         return ARB_GRANT_IF;
   endfunction

endpackage

// File: rtl/mem_bus_arb_wdt.sv
// mem_bus_arb_wdt: response watchdog for the bus arbiter.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clear     zero the counter (the arbiter asserts it on BUSY entry)
//   enable    count this cycle (high while BUSY)
//   expired   high while enabled and the count equals TIMEOUT
// TIMEOUT = 0 disables the watchdog, so expired never asserts.
module mem_bus_arb_wdt #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   // Keep at least one bit so TIMEOUT = 0 still elaborates.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
   localparam logic [CW-1:0] CMAX  = '1;

   logic [CW-1:0] count_reg;

   // The counter saturates at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count_reg <= '0;
      else if (clear)
         count_reg <= '0;
      else if (enable && (count_reg != CMAX))
         count_reg <= count_reg + 1'b1;
   end

   assign expired = (TIMEOUT != 0) && enable && (count_reg == LIMIT);

endmodule

// File: rtl/mem_bus_arb.sv
// mem_bus_arb: shares one external memory bus between the instruction-fetch
// port and the MEM-stage data port. It serves one transaction at a time,
// uses round-robin on ties, and returns an error if the downstream hangs.
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   if_*                  fetch requester: valid/addr/size in; ready/data/resp out
//   mem_*                 data requester: valid/req/addr/size/wdata in; ready/data/resp out
//   bus_*_o               downstream request; driven only while BUSY
//   bus_ready_i/data/resp downstream completion
// Completion data and response pass through combinationally in the ready cycle.
module mem_bus_arb
   import mem_bus_arb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     if_valid_i,
   input  logic [INST_ADDR_BUS-1:0] if_addr_i,
   input  logic [1:0]               if_size_i,
   output logic                     if_ready_o,
   output logic [DATA_BUS-1:0]      if_data_read_o,
   output logic [1:0]               if_resp_o,
   input  logic                     mem_valid_i,
   input  logic                     mem_req_i,
   input  logic [DATA_ADDR_BUS-1:0] mem_addr_i,
   input  logic [1:0]               mem_size_i,
   input  logic [DATA_BUS-1:0]      mem_data_write_i,
   output logic                     mem_ready_o,
   output logic [DATA_BUS-1:0]      mem_data_read_o,
   output logic [1:0]               mem_resp_o,
   output logic                     bus_valid_o,
   output logic                     bus_req_o,
   output logic [63:0]              bus_addr_o,
   output logic [1:0]               bus_size_o,
   output logic [DATA_BUS-1:0]      bus_data_write_o,
   input  logic                     bus_ready_i,
   input  logic [DATA_BUS-1:0]      bus_data_read_i,
   input  logic [1:0]               bus_resp_i
);

   arb_state_e          state_reg, state_next;
   arb_grant_e          grant_reg, grant_next;
   arb_grant_e          last_grant_reg, last_grant_next;
   logic                req_reg, req_next;
   logic [63:0]         addr_reg, addr_next;
   logic [1:0]          size_reg, size_next;
   logic [DATA_BUS-1:0] wdata_reg, wdata_next;

   logic                wdt_clear, wdt_enable, wdt_expired;
   logic                done;
   logic [DATA_BUS-1:0] done_data;
   logic [1:0]          done_resp;

   mem_bus_arb_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
      .clk     (clk),
      .rst     (rst),
      .clear   (wdt_clear),
      .enable  (wdt_enable),
      .expired (wdt_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ARB_IDLE;
         grant_reg      <= ARB_GRANT_IF;
         last_grant_reg <= ARB_GRANT_IF;
         req_reg        <= 1'b0;
         addr_reg       <= '0;
         size_reg       <= '0;
         wdata_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
         req_reg        <= req_next;
         addr_reg       <= addr_next;
         size_reg       <= size_next;
         wdata_reg      <= wdata_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      grant_next       = grant_reg;
      last_grant_next  = last_grant_reg;
      req_next         = req_reg;
      addr_next        = addr_reg;
      size_next        = size_reg;
      wdata_next       = wdata_reg;
      wdt_clear        = 1'b0;
      wdt_enable       = 1'b0;
      done             = 1'b0;
      done_data        = '0;
      done_resp        = RESP_OKAY;
      bus_valid_o      = 1'b0;
      bus_req_o        = 1'b0;
      bus_addr_o       = '0;
      bus_size_o       = '0;
      bus_data_write_o = '0;
      if_ready_o       = 1'b0;
      if_data_read_o   = '0;
      if_resp_o        = '0;
      mem_ready_o      = 1'b0;
      mem_data_read_o  = '0;
      mem_resp_o       = '0;

      case (state_reg)
         ARB_IDLE: begin
            // A stray bus_ready_i here is ignored.
            if (if_valid_i || mem_valid_i) begin
               grant_next = pick_grant(if_valid_i, mem_valid_i, last_grant_reg);
               state_next = ARB_BUSY;
               wdt_clear  = 1'b1;
               if (grant_next == ARB_GRANT_MEM) begin
                  req_next   = mem_req_i;
                  addr_next  = mem_addr_i;
                  size_next  = mem_size_i;
                  wdata_next = mem_data_write_i;
               end else begin
                  // Fetches are always reads with no store data.
                  req_next   = 1'b0;
                  addr_next  = if_addr_i;
                  size_next  = if_size_i;
                  wdata_next = '0;
               end
            end
         end
         ARB_BUSY: begin
            bus_valid_o      = 1'b1;
            bus_req_o        = req_reg;
            bus_addr_o       = addr_reg;
            bus_size_o       = size_reg;
            bus_data_write_o = wdata_reg;
            wdt_enable       = 1'b1;
            // A real response wins over a timeout in the same cycle.
            if (bus_ready_i) begin
               done            = 1'b1;
               done_data       = bus_data_read_i;
               done_resp       = bus_resp_i;
               last_grant_next = grant_reg;
               state_next      = ARB_IDLE;
            end else if (wdt_expired) begin
               done       = 1'b1;
               done_resp  = RESP_ERR;
               state_next = ARB_DRAIN;
            end
         end
         ARB_DRAIN: begin
            // Absorb the late response of the abandoned transaction.
            if (bus_ready_i)
               state_next = ARB_IDLE;
         end
         default: state_next = ARB_IDLE;
      endcase

      // Only the owner sees the completion.
      if (grant_reg == ARB_GRANT_MEM) begin
         mem_ready_o     = done;
         mem_data_read_o = done ? done_data : '0;
         mem_resp_o      = done ? done_resp : '0;
      end else begin
         if_ready_o      = done;
         if_data_read_o  = done ? done_data : '0;
         if_resp_o       = done ? done_resp : '0;
      end
   end

endmodule
